flag_unit: RTL
==============

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, and these SHALL be the first two ports.
REQ-002 Port list (name, direction, width, meaning), one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  flag-update request this cycle
- alu_op_i  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- src_a_i  input  32  operand A
- src_b_i  input  32  operand B
- flag_w_i  input  2  [1] write N,Z; [0] write C,V
- cond_ex_i  input  1  instruction passed its condition; 0 = no flag write
- flush_i  input  1  kill the in-flight request
- flags_o  output  4  {N,Z,C,V}, registered
- busy_o  output  1  flag write in flight; decoder stalls conditional instructions while high

Function
REQ-003 The unit SHALL be two stages. S1 registers the request; S2 computes flags and updates the flag register. flags_o SHALL change exactly 2 cycles after an accepted valid_i.
REQ-004 A request SHALL be accepted into S1 only if valid_i=1, cond_ex_i=1, flag_w_i!=00 and flush_i=0. Otherwise S1 SHALL hold a bubble.
REQ-005 flush_i=1 SHALL turn any S1 entry into a bubble and block capture of that cycle's input. An update already in S2 in that cycle SHALL still commit.
REQ-006 ADD/SUB SHALL use a 33-bit sum: a + (SUB ? ~b : b) + SUB. C = bit 32 (SUB: C=1 means no borrow). R = bits 31:0.
REQ-007 V for ADD SHALL be (a31==b31)&&(R31!=a31). V for SUB SHALL be (a31!=b31)&&(R31!=a31).
REQ-008 AND/ORR SHALL set R = a&b or a|b and SHALL never write C or V, whatever flag_w_i[0] is.
REQ-009 N SHALL be R[31] and Z SHALL be (R==0), for every op.
REQ-010 On commit, N,Z SHALL update only if stored flag_w[1]=1, and C,V only if stored flag_w[0]=1 (and the op is arithmetic). Bits not written SHALL hold their value.
REQ-011 busy_o SHALL equal (S1 valid) OR (S2 valid), combinationally from the stage-valid registers. busy_o SHALL drop in the cycle flags_o shows the final update.
REQ-012 Back-to-back requests SHALL be accepted every cycle at full throughput. Commits SHALL follow acceptance order.
REQ-013 Simultaneous events:
- new accept while S2 commits: both proceed.
- flush while S1 is empty: no effect.

Reset
REQ-014 While rst_n=0 (asserted asynchronously), the unit SHALL force flags_o=4'b0000, both stage-valid bits to 0 and busy_o=0.
REQ-015 Reset SHALL discard in-flight updates. The first request accepted after reset deasserts SHALL commit 2 cycles later.
REQ-016 Datapath pipeline registers other than the valid bits SHALL NOT need reset.

Structure
REQ-017 A shared package SHALL hold:
- the alu_op enumeration (ADD/SUB/AND/ORR);
- the flag bit-index constants N=3, Z=2, C=1, V=0;
- the 4-bit flags typedef.
The condition-evaluation logic SHALL use the same package.
REQ-018 Flag computation (REQ-006..009) SHALL live in one combinational sub-module, flag_gen. flag_unit SHALL hold only the pipeline registers, write masking and busy logic.

Verification
REQ-019 ADD 0x7FFFFFFF+0x00000001, flag_w=11 -> flags_o=1001 (N=1,Z=0,C=0,V=1) 2 cycles later; busy_o high for those 2 cycles.
REQ-020 SUB 5-5, flag_w=11 -> flags_o=0110 (Z=1,C=1). Then AND 0x80000000&0xFFFFFFFF, flag_w=11 -> flags_o=1010 (N=1; C,V held at 1,0).
REQ-021 Request with cond_ex_i=0 or flag_w=00 -> no acceptance, busy_o stays 0, flags_o unchanged.
REQ-022 Accept SUB 0-1 (result N=1,C=0), flush next cycle -> flags_o unchanged. In the same flush cycle, an S2 commit from the prior request SHALL still appear.
REQ-023 Three back-to-back ADDs with flag_w=10,01,11 -> flags_o updates on 3 consecutive cycles; each update touches only its masked bits.
REQ-024 Assert rst_n=0 mid-flight, asynchronously with respect to clk -> flags_o=0000 and busy_o=0 immediately; no later commit of the discarded request.

Source files
------------

// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag unit: ALU op encoding, flag bit positions
// and helpers used by both the flag pipeline and the decoder's condition check.
package flag_unit_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  // Logical ops never touch C/V, regardless of the requested write mask.
  function automatic flags_t flag_wr_mask(input logic [1:0] flag_w, input alu_op_e op);
    flags_t m;
    logic   arith;
    arith     = (op == ALU_ADD) || (op == ALU_SUB);
    m         = '0;
    m[FLAG_N] = flag_w[1];
    m[FLAG_Z] = flag_w[1];
    m[FLAG_C] = flag_w[0] & arith;
    m[FLAG_V] = flag_w[0] & arith;
    return m;
  endfunction

  function automatic logic cond_holds(input logic [3:0] cond, input flags_t f);
    logic r;
    case (cond[3:1])
      3'd0:    r = f[FLAG_Z];
      3'd1:    r = f[FLAG_C];
      3'd2:    r = f[FLAG_N];
      3'd3:    r = f[FLAG_V];
      3'd4:    r = f[FLAG_C] & ~f[FLAG_Z];
      3'd5:    r = (f[FLAG_N] == f[FLAG_V]);
      3'd6:    r = (f[FLAG_N] == f[FLAG_V]) & ~f[FLAG_Z];
      default: r = 1'b1;
    endcase
    return (cond == 4'hE) ? 1'b1 : (r ^ cond[0]);
  endfunction

endpackage

// File: rtl/flag_unit_flag_gen.sv
// Combinational flag generation: computes N,Z,C,V for one ALU op.
// C/V are driven to zero for logical ops; the write mask keeps them from committing.
module flag_gen
  import flag_unit_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output flags_t      flags_o
);

  logic        is_sub;
  logic [32:0] sum;
  logic [31:0] res;
  logic        c;
  logic        v;

  always_comb begin
    is_sub = (op_i == ALU_SUB);
    // SUB as a + ~b + 1, so C=1 means no borrow
    sum    = {1'b0, a_i} + {1'b0, (is_sub ? ~b_i : b_i)} + {32'd0, is_sub};
    res    = sum[31:0];
    c      = 1'b0;
    v      = 1'b0;
    case (op_i)
      ALU_ADD: begin
        c = sum[32];
        v = (a_i[31] == b_i[31]) && (res[31] != a_i[31]);
      end
      ALU_SUB: begin
        c = sum[32];
        v = (a_i[31] != b_i[31]) && (res[31] != a_i[31]);
      end
      ALU_AND: res = a_i & b_i;
      default: res = a_i | b_i;
    endcase
    flags_o         = '0;
    flags_o[FLAG_N] = res[31];
    flags_o[FLAG_Z] = (res == 32'd0);
    flags_o[FLAG_C] = c;
    flags_o[FLAG_V] = v;
  end

endmodule

// File: rtl/flag_unit.sv
// Two-stage flag update pipeline: S1 captures the request, S2 computes and commits
// masked flags. busy_o lets the decoder stall conditional instructions.
module flag_unit
  import flag_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [1:0]  alu_op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [1:0]  flag_w_i,
  input  logic        cond_ex_i,
  input  logic        flush_i,
  output logic [3:0]  flags_o,
  output logic        busy_o
);

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  alu_op_e     s1_op_q, s2_op_q;
  logic [31:0] s1_a_q, s1_b_q, s2_a_q, s2_b_q;
  logic [1:0]  s1_fw_q, s2_fw_q;
  flags_t      flags_q, flags_d;
  flags_t      gen_flags;
  flags_t      wr_mask;
  logic        accept;

  flag_gen u_flag_gen (
    .op_i    (s2_op_q),
    .a_i     (s2_a_q),
    .b_i     (s2_b_q),
    .flags_o (gen_flags)
  );

  always_comb begin
    accept     = valid_i & cond_ex_i & (flag_w_i != 2'b00) & ~flush_i;
    s1_valid_d = accept;
    // flush kills only the S1 entry; whatever is in S2 still commits
    s2_valid_d = s1_valid_q & ~flush_i;
    wr_mask    = flag_wr_mask(s2_fw_q, s2_op_q);
    flags_d    = flags_q;
    if (s2_valid_q) begin
      flags_d = (flags_q & ~wr_mask) | (gen_flags & wr_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      flags_q    <= flags_d;
    end
  end

  // Datapath registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q <= alu_op_e'(alu_op_i);
      s1_a_q  <= src_a_i;
      s1_b_q  <= src_b_i;
      s1_fw_q <= flag_w_i;
    end
    if (s1_valid_q) begin
      s2_op_q <= s1_op_q;
      s2_a_q  <= s1_a_q;
      s2_b_q  <= s1_b_q;
      s2_fw_q <= s1_fw_q;
    end
  end

  assign flags_o = flags_q;
  assign busy_o  = s1_valid_q | s2_valid_q;

endmodule
